// File: rtl/alu_pkg.sv
// Shared ALU command codes and helpers used by the ALU, the command decoder and the arbiter.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_cmd_e;

  // Highest legal command code; everything above it is flagged as an error.
  localparam logic [3:0] ALU_CMD_MAX = 4'b1001;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

  function automatic logic alu_cmd_legal(input logic [3:0] cmd);
    return (cmd <= ALU_CMD_MAX);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU; shifts use rs2[4:0], illegal commands yield zero.
module alu_share_arbiter_alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [3:0]      alu_cmd,
  output logic [XLEN-1:0] out
);

  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic [4:0]             shamt;

  assign rs1_s = signed'(rs1);
  assign rs2_s = signed'(rs2);
  assign shamt = rs2[4:0];

  always_comb begin
    out = '0;
    case (alu_cmd)
      ALU_ADD:  out = rs1 + rs2;
      ALU_SUB:  out = rs1 - rs2;
      ALU_SLT:  out = {{(XLEN-1){1'b0}}, (rs1_s < rs2_s)};
      ALU_SLTU: out = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
      ALU_AND:  out = rs1 & rs2;
      ALU_OR:   out = rs1 | rs2;
      ALU_XOR:  out = rs1 ^ rs2;
      ALU_SLL:  out = rs1 << shamt;
      ALU_SRL:  out = rs1 >> shamt;
      ALU_SRA:  out = unsigned'(rs1_s >>> shamt);
      default:  out = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter sharing one ALU, with a single registered response slot.
module alu_share_arbiter
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [XLEN-1:0] req0_rs1,
  input  logic [XLEN-1:0] req0_rs2,
  input  logic [3:0]      req0_cmd,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [XLEN-1:0] req1_rs1,
  input  logic [XLEN-1:0] req1_rs2,
  input  logic [3:0]      req1_cmd,
  output logic            req1_ready,
  output logic            resp_valid,
  output logic            resp_id,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err,
  input  logic            resp_ready
);

  arb_state_e      state_q;
  logic            last_q;
  logic            id_q;
  logic [XLEN-1:0] data_q;
  logic            err_q;

  logic            can_accept_d;
  logic            sel1_d;
  logic            accept_d;
  logic [XLEN-1:0] op_a_d;
  logic [XLEN-1:0] op_b_d;
  logic [3:0]      cmd_d;
  logic [XLEN-1:0] alu_out;
  logic            legal_d;

  // The slot may refill in the same cycle its response leaves (back-to-back).
  always_comb begin
    can_accept_d = ~rst & ((state_q == ST_EMPTY) | resp_ready);
    sel1_d       = req1_valid & (~req0_valid | ~last_q);
    req0_ready   = can_accept_d & req0_valid & ~sel1_d;
    req1_ready   = can_accept_d & sel1_d;
    accept_d     = req0_ready | req1_ready;
    op_a_d       = sel1_d ? req1_rs1 : req0_rs1;
    op_b_d       = sel1_d ? req1_rs2 : req0_rs2;
    cmd_d        = sel1_d ? req1_cmd : req0_cmd;
    legal_d      = alu_cmd_legal(cmd_d);
  end

  alu_share_arbiter_alu u_alu (
    .rs1     (op_a_d),
    .rs2     (op_b_d),
    .alu_cmd (cmd_d),
    .out     (alu_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else if (accept_d) begin
      state_q <= ST_FULL;
      last_q  <= sel1_d;
      id_q    <= sel1_d;
      data_q  <= legal_d ? alu_out : '0;
      err_q   <= ~legal_d;
    end else if ((state_q == ST_FULL) && resp_ready) begin
      state_q <= ST_EMPTY;
    end
  end

  assign resp_valid = (state_q == ST_FULL);
  assign resp_id    = id_q;
  assign resp_data  = data_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic [31:0] req0_rs1 = '0;
  logic [31:0] req0_rs2 = '0;
  logic [3:0]  req0_cmd = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [31:0] req1_rs1 = '0;
  logic [31:0] req1_rs2 = '0;
  logic [3:0]  req1_cmd = '0;
  logic        req1_ready;
  logic        resp_valid;
  logic        resp_id;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        resp_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  // Behavioural model state: one response slot plus who won last.
  bit          m_valid = 0;
  bit          m_id = 0;
  logic [31:0] m_data = '0;
  bit          m_err = 0;
  int          m_last = 1;

  alu_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
    .req0_cmd(req0_cmd), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
    .req1_cmd(req1_cmd), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_err(resp_err), .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b, output bit err);
    int unsigned sh;
    logic [31:0] r;
    sh  = b % 32;
    err = 0;
    case (cmd)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3: r = (a < b) ? 32'd1 : 32'd0;
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: r = a << sh;
      4'd8: r = a >> sh;
      4'd9: begin
        r = a >> sh;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      default: begin r = 32'd0; err = 1; end
    endcase
    return r;
  endfunction

  function automatic void exp_ready(output bit r0, output bit r1);
    r0 = 0;
    r1 = 0;
    if (!rst && (!m_valid || resp_ready)) begin
      if (req0_valid && req1_valid) begin
        if (m_last == 0) r1 = 1; else r0 = 1;
      end else if (req0_valid) r0 = 1;
      else if (req1_valid) r1 = 1;
    end
  endfunction

  // Compare on the falling edge, advance the model on the rising edge.
  initial begin
    bit r0, r1, e;
    forever begin
      @(negedge clk);
      exp_ready(r0, r1);
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, r0});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, r1});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_valid});
      if (m_valid) begin
        chk("resp_id", {31'd0, resp_id}, {31'd0, m_id});
        chk("resp_data", resp_data, m_data);
        chk("resp_err", {31'd0, resp_err}, {31'd0, m_err});
      end
      @(posedge clk);
      if (rst) begin
        m_valid = 0; m_id = 0; m_data = '0; m_err = 0; m_last = 1;
      end else begin
        exp_ready(r0, r1);
        if (r0 || r1) begin
          m_valid = 1;
          m_id    = r1;
          m_data  = r1 ? ref_alu(req1_cmd, req1_rs1, req1_rs2, e)
                       : ref_alu(req0_cmd, req0_rs1, req0_rs2, e);
          m_err   = e;
          m_last  = r1 ? 1 : 0;
        end else if (m_valid && resp_ready) begin
          m_valid = 0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit a0, a1;
    // Reset, with a request present that must not be accepted.
    cyc();
    req0_valid = 1; req0_rs1 = 32'h8000_0000; req0_rs2 = 32'd8; req0_cmd = 4'b1001;
    cyc();
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_id", {31'd0, resp_id}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);

    // SRA from requester 0, response one cycle after accept.
    rst = 0;
    cyc();
    req0_valid = 0;
    chk("sra_valid", {31'd0, resp_valid}, 32'd1);
    chk("sra_id", {31'd0, resp_id}, 32'd0);
    chk("sra_data", resp_data, 32'hFF80_0000);
    chk("sra_err", {31'd0, resp_err}, 32'd0);

    // Requester 1: SLT, SLTU, SLL by 33.
    req1_valid = 1; req1_rs1 = 32'hFFFF_FFFF; req1_rs2 = 32'd1; req1_cmd = 4'b0010;
    cyc();
    chk("slt_data", resp_data, 32'd1);
    chk("slt_id", {31'd0, resp_id}, 32'd1);
    req1_cmd = 4'b0011;
    cyc();
    chk("sltu_data", resp_data, 32'd0);
    req1_rs1 = 32'd3; req1_rs2 = 32'd33; req1_cmd = 4'b0111;
    cyc();
    chk("sll33_data", resp_data, 32'd6);

    // Both valid continuously: grants alternate 0,1,0,1.
    req0_valid = 1; req0_rs1 = 32'd5; req0_rs2 = 32'd7; req0_cmd = 4'b0000;
    req1_valid = 1; req1_rs1 = 32'd5; req1_rs2 = 32'd7; req1_cmd = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("alt_valid", {31'd0, resp_valid}, 32'd1);
      chk("alt_id", {31'd0, resp_id}, 32'(i % 2));
      chk("alt_data", resp_data, (i % 2) ? 32'hFFFF_FFFE : 32'h0000_000C);
    end

    // Consumer stalls for 3 cycles, then releases.
    resp_ready = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_valid", {31'd0, resp_valid}, 32'd1);
      chk("stall_id", {31'd0, resp_id}, 32'd1);
      chk("stall_data", resp_data, 32'hFFFF_FFFE);
      chk("stall_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    resp_ready = 1;
    #1;
    chk("handoff_ready0", {31'd0, req0_ready}, 32'd1);
    cyc();
    chk("handoff_id", {31'd0, resp_id}, 32'd0);
    chk("handoff_data", resp_data, 32'h0000_000C);

    // Illegal command from requester 1.
    req0_valid = 0; req1_cmd = 4'b1100;
    cyc();
    chk("illegal_id", {31'd0, resp_id}, 32'd1);
    chk("illegal_data", resp_data, 32'd0);
    chk("illegal_err", {31'd0, resp_err}, 32'd1);

    // Reset while holding a response, then first tie goes to requester 0.
    req1_valid = 0; resp_ready = 0;
    cyc();
    chk("full_hold", {31'd0, resp_valid}, 32'd1);
    rst = 1;
    cyc();
    chk("rst_full_valid", {31'd0, resp_valid}, 32'd0);
    rst = 0;
    req0_valid = 1; req1_valid = 1; req1_cmd = 4'b0001;
    #1;
    chk("tie_after_rst", {30'd0, req1_ready, req0_ready}, 32'd1);
    resp_ready = 1;
    cyc();
    chk("tie_after_rst_id", {31'd0, resp_id}, 32'd0);

    // Randomized traffic; requests are held until accepted.
    a0 = 1; a1 = 1;
    for (int n = 0; n < 3000; n++) begin
      if (!req0_valid || a0) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_rs1 = rnd_op(); req0_rs2 = rnd_op(); req0_cmd = 4'($urandom_range(0, 15));
      end
      if (!req1_valid || a1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_rs1 = rnd_op(); req1_rs2 = rnd_op(); req1_cmd = 4'($urandom_range(0, 15));
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      cyc();
    end
    req0_valid = 0; req1_valid = 0; resp_ready = 1;
    cyc(); cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 The block SHALL use one clock and synchronous active-high reset: clk input 1 (rising-edge clock); rst input 1 (synchronous, active-high reset).
REQ-002 The block SHALL have no parameters; the number of requesters is fixed at 2 and the data width at 32.
REQ-003 For each requester n in {0,1}, the block SHALL provide the request inputs reqN_valid (1, request present), reqN_rs1 (32, operand A), reqN_rs2 (32, operand B) and reqN_cmd (4, ALU command).
REQ-004 For each requester n, the block SHALL provide the output reqN_ready (1), which is high when the request is accepted this cycle.
REQ-005 The block SHALL provide the response outputs resp_valid (1, result held), resp_id (1, source requester), resp_data (32, ALU result) and resp_err (1, illegal command flag).
REQ-006 The block SHALL provide the response input resp_ready (1, consumer accepts the response).

Function
REQ-007 A request SHALL transfer when reqN_valid and reqN_ready are both high on a rising edge; a response SHALL transfer when resp_valid and resp_ready are both high.
REQ-008 Output register state machine:
- EMPTY -> FULL on accept.
- FULL -> EMPTY on response transfer with no new accept.
- FULL -> FULL on response transfer with a simultaneous accept (back-to-back).
- FULL holds while resp_ready is low.
REQ-009 Grant may be asserted only when (state == EMPTY) or (resp_valid && resp_ready).
- At most one reqN_ready is high per cycle.
- reqN_ready is combinational from the valids, state, resp_ready and the priority pointer.
REQ-010 Arbitration SHALL be round-robin:
- Only one valid: that requester is granted.
- Both valid: the requester not granted most recently is granted.
- The 1-bit last-grant pointer updates only on an actual accept.
REQ-011 The granted operands SHALL feed one shared ALU instance; its result, the granted id and the error flag SHALL be registered at the accept edge, giving resp_valid exactly 1 cycle after accept.
REQ-012 ALU command encoding:
- 0000 ADD, 0001 SUB, 0010 SLT (signed), 0011 SLTU, 0100 AND, 0101 OR, 0110 XOR, 0111 SLL, 1000 SRL, 1001 SRA.
- Shift commands use rs2[4:0] only.
- All arithmetic is modulo 2^32.
REQ-013 Commands 1010-1111 SHALL be accepted normally but produce resp_data = 0 and resp_err = 1; legal commands produce resp_err = 0.
REQ-014 While resp_valid is high and resp_ready is low, resp_data, resp_id and resp_err SHALL hold stable.
REQ-015 Requesters SHALL hold their request stable until accepted; the block does not buffer unaccepted requests.
REQ-016 Throughput SHALL be one result per cycle when resp_ready is held high and requests are continuous.

Reset
REQ-017 While rst is high, at every rising edge:
- state = EMPTY and resp_valid = 0.
- resp_id = 0, resp_data = 0 and resp_err = 0.
- The last-grant pointer = 1, so requester 0 wins the first tie.
REQ-018 reqN_ready SHALL be 0 while rst is high.
REQ-019 Reset asserted while in FULL SHALL discard the held response without a transfer.

Structure
REQ-020 The ALU command codes SHALL live in a shared package (alu_pkg) used by this block, the ALU and the decoder.
REQ-021 The legal-command upper bound (1001) SHALL also live in alu_pkg.
REQ-022 The existing combinational ALU (ports rs1, rs2, alu_cmd, out) SHALL be instantiated once as a sub-module.
REQ-023 Arbitration, the state machine and the output register SHALL be local logic, with no other sub-modules.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- req0 only, rs1=80000000h, rs2=8, cmd=SRA -> 1 cycle later resp_valid=1, resp_id=0, resp_data=FF800000h, resp_err=0.
- Both valid every cycle, resp_ready=1, req0 ADD 5+7, req1 SUB 5-7 -> grants alternate 0,1,0,1 starting with 0; responses 0000000Ch and FFFFFFFEh, one per cycle.
- resp_ready=0 for 3 cycles after a response is held -> resp_* stable, both reqN_ready=0; resp_ready=1 -> the response transfers and the waiting request is accepted the same cycle.
- cmd=1100b from req1 -> resp_data=0, resp_err=1, resp_id=1.
- req1 SLT with rs1=FFFFFFFFh, rs2=1 -> 1; SLTU with the same operands -> 0; SLL by rs2=33 -> shift by 1.
- rst asserted while FULL -> next cycle resp_valid=0; the first tie after reset grants requester 0.
